// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared constants and helper functions for the round-robin arbitrated
// registered multiplexer (rr_arb_mux) and its grant finder (rr_grant).
//   DEFAULT_WIDTH : default per-channel data width
//   sel_width(n)  : index width needed to address n channels (minimum 1)
//   next_ptr(g,n) : channel after g, wrapping n-1 -> 0 explicitly so that
//                   non-power-of-2 channel counts never reach index >= n
// ---------------------------------------------------------------------------
package mux_pkg;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int next_ptr(input int g, input int n);
      return (g >= n - 1) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/rr_grant.sv
// ---------------------------------------------------------------------------
// rr_grant
// Purely combinational rotate-priority finder. Searches req starting at ptr,
// then ptr+1, ..., NUM_PORTS-1, 0, ..., ptr-1 and reports the first channel
// found.
// Ports:
//   req         in  [NUM_PORTS]  request vector, bit i = channel i
//   ptr         in  [SEL_WIDTH]  highest-priority channel (always < NUM_PORTS)
//   grant       out [SEL_WIDTH]  index of the winning channel (0 when none)
//   grant_valid out              at least one request present
// ---------------------------------------------------------------------------
module rr_grant
   import mux_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int SEL_WIDTH = sel_width(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [SEL_WIDTH-1:0] ptr,
   output logic [SEL_WIDTH-1:0] grant,
   output logic                 grant_valid
);

   localparam logic [SEL_WIDTH:0] PORTS_W = (SEL_WIDTH + 1)'(NUM_PORTS);

   // rot_idx[k] is the channel examined at search offset k from ptr.
   logic [SEL_WIDTH-1:0] rot_idx [NUM_PORTS];
   logic [NUM_PORTS-1:0] req_rot;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
         // ptr + offset < 2*NUM_PORTS, so one conditional subtract is a
         // complete modulo and works for any channel count.
         logic [SEL_WIDTH:0] sum;
         assign sum          = {1'b0, ptr} + (SEL_WIDTH + 1)'(gi);
         assign rot_idx[gi]  = (sum >= PORTS_W) ? SEL_WIDTH'(sum - PORTS_W)
                                                : sum[SEL_WIDTH-1:0];
         assign req_rot[gi]  = req[rot_idx[gi]];
      end
   endgenerate

   // Scan from the farthest offset down so the smallest offset wins.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            grant       = rot_idx[k];
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// ---------------------------------------------------------------------------
// rr_arb_mux
// N-input registered multiplexer with valid/ready handshaking and
// round-robin arbitration. One transfer per cycle, one cycle of latency;
// a new word loads on the same edge the held word is consumed.
// Ports:
//   clk        in                     clock, rising edge
//   rst        in                     asynchronous active-high reset
//   in_valid   in  [NUM_PORTS]        per-channel valid
//   in_data    in  [NUM_PORTS*W]      flattened data, channel i at [i*W +: W]
//   in_ready   out [NUM_PORTS]        per-channel ready (combinational)
//   out_valid  out                    output register holds valid data
//   out_data   out [W]                registered data
//   out_sel    out [SEL_WIDTH]        channel that supplied out_data
//   out_ready  in                     consumer accepts out_data this cycle
// Optional build macro FORCE_SEL_EN adds:
//   force_en   in                     override arbitration with force_sel
//   force_sel  in  [SEL_WIDTH]        forced channel (>= NUM_PORTS grants none)
// ---------------------------------------------------------------------------
module rr_arb_mux
   import mux_pkg::*;
#(
   parameter  int WIDTH_DATA_LENGTH = DEFAULT_WIDTH,
   parameter  int NUM_PORTS         = 4,
   localparam int SEL_WIDTH         = sel_width(NUM_PORTS)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_PORTS-1:0]                   in_valid,
   input  logic [NUM_PORTS*WIDTH_DATA_LENGTH-1:0] in_data,
   output logic [NUM_PORTS-1:0]                   in_ready,
`ifdef FORCE_SEL_EN
   input  logic                                   force_en,
   input  logic [SEL_WIDTH-1:0]                   force_sel,
`endif
   output logic                                   out_valid,
   output logic [WIDTH_DATA_LENGTH-1:0]           out_data,
   output logic [SEL_WIDTH-1:0]                   out_sel,
   input  logic                                   out_ready
);

   logic                         out_valid_reg, out_valid_next;
   logic [WIDTH_DATA_LENGTH-1:0] out_data_reg,  out_data_next;
   logic [SEL_WIDTH-1:0]         out_sel_reg,   out_sel_next;
   logic [SEL_WIDTH-1:0]         rr_ptr_reg,    rr_ptr_next;

   logic                         can_load;
   logic [SEL_WIDTH-1:0]         rr_idx, g_idx;
   logic                         rr_valid, g_valid;
   logic                         forced;
   logic [WIDTH_DATA_LENGTH-1:0] ch_data [NUM_PORTS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_chan
         assign ch_data[gi]  = in_data[gi*WIDTH_DATA_LENGTH +: WIDTH_DATA_LENGTH];
         // g_valid already implies in_valid[g_idx]; in_data is never consulted.
         assign in_ready[gi] = can_load && g_valid && (g_idx == SEL_WIDTH'(gi));
      end
   endgenerate

   rr_grant #(
      .NUM_PORTS (NUM_PORTS),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_grant (
      .req         (in_valid),
      .ptr         (rr_ptr_reg),
      .grant       (rr_idx),
      .grant_valid (rr_valid)
   );

`ifdef FORCE_SEL_EN
   localparam logic [SEL_WIDTH:0] PORTS_W = (SEL_WIDTH + 1)'(NUM_PORTS);

   always_comb begin
      forced  = force_en;
      g_idx   = rr_idx;
      g_valid = rr_valid;
      if (force_en) begin
         g_idx   = force_sel;
         // Range check first: out-of-range channels exist only in the index space.
         g_valid = ({1'b0, force_sel} < PORTS_W) && in_valid[force_sel];
      end
   end
`else
   assign forced  = 1'b0;
   assign g_idx   = rr_idx;
   assign g_valid = rr_valid;
`endif

   assign can_load = !out_valid_reg || out_ready;

   always_comb begin
      out_valid_next = out_valid_reg;
      out_data_next  = out_data_reg;
      out_sel_next   = out_sel_reg;
      rr_ptr_next    = rr_ptr_reg;
      if (can_load) begin
         // Draining with nothing to load clears valid but keeps data/sel.
         out_valid_next = g_valid;
         if (g_valid) begin
            out_data_next = ch_data[g_idx];
            out_sel_next  = g_idx;
            // Forced transfers leave the round-robin order untouched.
            if (!forced)
               rr_ptr_next = SEL_WIDTH'(next_ptr(int'(g_idx), NUM_PORTS));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sel_reg   <= '0;
         rr_ptr_reg    <= '0;
      end else begin
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         out_sel_reg   <= out_sel_next;
         rr_ptr_reg    <= rr_ptr_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_rr_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_mux
// Directed bench for rr_arb_mux (4 channels, 8-bit data). Covers the forced
// selection scenario when built with FORCE_SEL_EN.
// ---------------------------------------------------------------------------
module tb_rr_arb_mux;

   localparam int W = 8;
   localparam int N = 4;
   localparam int S = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N-1:0]     in_valid = '0;
   logic [N*W-1:0]   in_data = '0;
   logic [N-1:0]     in_ready;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic [S-1:0]     out_sel;
   logic             out_ready = 1'b0;
`ifdef FORCE_SEL_EN
   logic             force_en = 1'b0;
   logic [S-1:0]     force_sel = '0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   rr_arb_mux #(
      .WIDTH_DATA_LENGTH (W),
      .NUM_PORTS         (N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
`ifdef FORCE_SEL_EN
      .force_en  (force_en),
      .force_sel (force_sel),
`endif
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input logic [W-1:0] d2, input logic [W-1:0] d3);
      in_data = {d3, d2, d1, d0};
   endtask

   task automatic do_reset();
      in_valid  = '0;
      out_ready = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      in_valid  = 4'b1111;
      set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      n_checks++;
      if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", out_data); end
      n_checks++;
      if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", out_sel); end
      n_checks++;
      if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0001", in_ready); end
      rst = 1'b0;
      tick();
      $display("[reset] first grant sel=%0d data=%h valid=%b", out_sel, out_data, out_valid);
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'hA0) begin
         n_fail++;
         $display("FAIL reset_first_grant: got v=%b sel=%0d data=%h expected v=1 sel=0 data=a0",
                  out_valid, out_sel, out_data);
      end
   endtask

   task automatic test_rotation();
      logic [S-1:0] exp_sel;
      logic [W-1:0] exp_data;
      logic [N-1:0] exp_rdy;
      do_reset();
      set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
      in_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         exp_sel  = S'(k % N);
         exp_data = 8'hA0 + W'(k % N);
         exp_rdy  = N'(1) << ((k + 1) % N);
         $display("[rotation] k=%0d sel=%0d data=%h in_ready=%b", k, out_sel, out_data, in_ready);
         n_checks++;
         if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== exp_data) begin
            n_fail++;
            $display("FAIL rotation_%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                     k, out_valid, out_sel, out_data, exp_sel, exp_data);
         end
         n_checks++;
         if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL rotation_ready_%0d: got %b expected %b", k, in_ready, exp_rdy);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      set_data(8'h5A, 8'h11, 8'h22, 8'h33);
      in_valid = 4'b0001;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_empty_ready: got %b expected 0001", in_ready); end
      tick();
      in_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++;
         if (in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_ready_%0d: got %b expected 0000", k, in_ready);
         end
         tick();
         $display("[backpressure] cycle=%0d sel=%0d data=%h valid=%b", k, out_sel, out_data, out_valid);
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h5A || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got v=%b sel=%0d data=%h expected v=1 sel=0 data=5a",
                     k, out_valid, out_sel, out_data);
         end
      end
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", in_ready); end
      tick();
      $display("[backpressure] release sel=%0d data=%h valid=%b", out_sel, out_data, out_valid);
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'h11) begin
         n_fail++;
         $display("FAIL bp_release_load: got v=%b sel=%0d data=%h expected v=1 sel=1 data=11",
                  out_valid, out_sel, out_data);
      end
   endtask

   task automatic test_skip_wrap();
      do_reset();
      set_data(8'hC0, 8'hC1, 8'hC2, 8'hC3);
      in_valid = 4'b0100;
      tick();
      n_checks++;
      if (out_sel !== 2'd2 || out_data !== 8'hC2) begin
         n_fail++;
         $display("FAIL skip_setup: got sel=%0d data=%h expected sel=2 data=c2", out_sel, out_data);
      end
      in_valid = 4'b0010;
      #1;
      n_checks++;
      if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL skip_ready: got %b expected 0010", in_ready); end
      tick();
      $display("[skip_wrap] sel=%0d data=%h", out_sel, out_data);
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'hC1) begin
         n_fail++;
         $display("FAIL skip_grant1: got v=%b sel=%0d data=%h expected v=1 sel=1 data=c1",
                  out_valid, out_sel, out_data);
      end
      in_valid = 4'b1001;
      #1;
      n_checks++;
      if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_ready3: got %b expected 1000", in_ready); end
      tick();
      $display("[skip_wrap] sel=%0d data=%h", out_sel, out_data);
      n_checks++;
      if (out_sel !== 2'd3 || out_data !== 8'hC3) begin
         n_fail++;
         $display("FAIL wrap_grant3: got sel=%0d data=%h expected sel=3 data=c3", out_sel, out_data);
      end
      n_checks++;
      if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ready0: got %b expected 0001", in_ready); end
      tick();
      $display("[skip_wrap] sel=%0d data=%h", out_sel, out_data);
      n_checks++;
      if (out_sel !== 2'd0 || out_data !== 8'hC0) begin
         n_fail++;
         $display("FAIL wrap_grant0: got sel=%0d data=%h expected sel=0 data=c0", out_sel, out_data);
      end
   endtask

   task automatic test_idle_drain();
      do_reset();
      set_data(8'h3C, 8'h00, 8'h00, 8'h00);
      in_valid = 4'b0001;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
         n_fail++;
         $display("FAIL drain_load: got v=%b data=%h expected v=1 data=3c", out_valid, out_data);
      end
      in_valid = 4'b0000;
      for (int k = 0; k < 2; k++) begin
         tick();
         $display("[idle_drain] cycle=%0d valid=%b data=%h sel=%0d", k, out_valid, out_data, out_sel);
         n_checks++;
         if (out_valid !== 1'b0 || out_data !== 8'h3C || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL drain_%0d: got v=%b data=%h sel=%0d expected v=0 data=3c sel=0",
                     k, out_valid, out_data, out_sel);
         end
      end
   endtask

`ifdef FORCE_SEL_EN
   task automatic test_force_sel();
      do_reset();
      set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
      in_valid  = 4'b1111;
      force_en  = 1'b1;
      force_sel = 2'd2;
      #1;
      n_checks++;
      if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL force_ready: got %b expected 0100", in_ready); end
      for (int k = 0; k < 3; k++) begin
         tick();
         $display("[force] k=%0d sel=%0d data=%h", k, out_sel, out_data);
         n_checks++;
         if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'hA2) begin
            n_fail++;
            $display("FAIL force_grant_%0d: got v=%b sel=%0d data=%h expected v=1 sel=2 data=a2",
                     k, out_valid, out_sel, out_data);
         end
      end
      force_en = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL force_ptr_kept: got %b expected 0001", in_ready); end
      tick();
      force_en = 1'b1;
      in_valid = 4'b1011;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL force_none_ready: got %b expected 0000", in_ready); end
      tick();
      $display("[force] idle channel valid=%b", out_valid);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL force_none_valid: got %b expected 0", out_valid); end
      force_en = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_rotation();
      test_backpressure();
      test_skip_wrap();
      test_idle_drain();
`ifdef FORCE_SEL_EN
      test_force_sel();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
